// File: rtl/sm_als_spi_master_pkg.sv
// sm_als_spi_master_pkg: PmodALS frame layout, FSM states and padding check shared by the ALS SPI master.
package sm_als_spi_master_pkg;

  localparam int ALS_FRAME_BITS = 16;
  localparam int ALS_DATA_MSB = 12;
  localparam int ALS_DATA_LSB = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_QUIET = 2'd3
  } alsState_t;

  function automatic logic padErr(input logic [ALS_FRAME_BITS-1:0] f);
    return |{f[ALS_FRAME_BITS-1:ALS_DATA_MSB+1], f[ALS_DATA_LSB-1:0]};
  endfunction

endpackage

// File: rtl/sm_als_spi_master_sck_gen.sv
// sm_als_sck_gen: SCK divider; strobes mark the clk edges where SCK rises or falls, restarting low when disabled.
module sm_als_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(SCK_DIV) + 1;

  logic [DW-1:0] divCnt;
  logic          level;
  logic          wrap;

  assign wrap = en && (divCnt == DW'(SCK_DIV - 1));
  assign rise = wrap && !level;
  assign fall = wrap && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt <= '0;
      level  <= 1'b0;
    end else if (!en) begin
      divCnt <= '0;
      level  <= 1'b0;
    end else if (wrap) begin
      divCnt <= '0;
      level  <= ~level;
    end else begin
      divCnt <= divCnt + DW'(1);
    end
  end

endmodule

// File: rtl/sm_als_spi_master.sv
// sm_als_spi_master: reads one 16-clock PmodALS frame per start request and reports the 8-bit light value.
module sm_als_spi_master
  import sm_als_spi_master_pkg::*;
#(
  parameter int SCK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int QUIET    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       valid,
  output logic [7:0] value,
  output logic       frameErr,
  output logic       alsCS,
  output logic       alsSCK,
  input  logic       alsSDO
);

  localparam int PW = $clog2((CS_SETUP > QUIET ? CS_SETUP : QUIET) + 1) + 1;

  alsState_t                  state, stateNext;
  logic [PW-1:0]              phase, phaseNext;
  logic [4:0]                 bitCnt, bitCntNext;
  logic [ALS_FRAME_BITS-1:0]  shift, shiftNext;
  logic [7:0]                 valueNext;
  logic                       busyNext, validNext, frameErrNext, csNext, sckNext;
  logic                       sckRise, sckFall;

  sm_als_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == S_SHIFT),
    .rise (sckRise),
    .fall (sckFall)
  );

  always_comb begin
    stateNext    = state;
    phaseNext    = phase + PW'(1);
    bitCntNext   = bitCnt;
    shiftNext    = shift;
    busyNext     = busy;
    validNext    = 1'b0;
    valueNext    = value;
    frameErrNext = frameErr;
    csNext       = alsCS;
    sckNext      = alsSCK;
    case (state)
      S_IDLE: begin
        phaseNext = '0;
        if (start) begin
          stateNext = S_SETUP;
          csNext    = 1'b0;
          busyNext  = 1'b1;
        end
      end
      S_SETUP: begin
        if (phase == PW'(CS_SETUP)) begin
          stateNext  = S_SHIFT;
          sckNext    = 1'b0;
          bitCntNext = '0;
        end
      end
      S_SHIFT: begin
        phaseNext = '0;
        if (sckRise) begin
          sckNext    = 1'b1;
          shiftNext  = {shift[ALS_FRAME_BITS-2:0], alsSDO};
          bitCntNext = bitCnt + 5'd1;
        end else if (sckFall) begin
          // The fall that would open a 17th bit instead closes the frame with SCK left high.
          if (bitCnt == 5'(ALS_FRAME_BITS)) begin
            stateNext    = S_QUIET;
            csNext       = 1'b1;
            validNext    = 1'b1;
            valueNext    = shift[ALS_DATA_MSB:ALS_DATA_LSB];
            frameErrNext = padErr(shift);
          end else begin
            sckNext = 1'b0;
          end
        end
      end
      default: begin
        if (phase == PW'(QUIET - 1)) begin
          stateNext = S_IDLE;
          busyNext  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      bitCnt   <= '0;
      shift    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      value    <= 8'h00;
      frameErr <= 1'b0;
      alsCS    <= 1'b1;
      alsSCK   <= 1'b1;
    end else begin
      state    <= stateNext;
      phase    <= phaseNext;
      bitCnt   <= bitCntNext;
      shift    <= shiftNext;
      busy     <= busyNext;
      valid    <= validNext;
      value    <= valueNext;
      frameErr <= frameErrNext;
      alsCS    <= csNext;
      alsSCK   <= sckNext;
    end
  end

endmodule

// File: tb/tb_sm_als_spi_master.sv
// tb_sm_als_spi_master: directed and random frames from an ADC slave model, checked for value, timing and SPI protocol.
module tb_sm_als_spi_master;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0, sdo = 1'b0;
  logic busy1, valid1, err1, cs1, sck1, busy2, valid2, err2, cs2, sck2;
  logic [7:0] value1, value2;
  logic busy, valid, err, cs, sck;
  logic [7:0] value;
  logic [15:0] frame = 16'h0000;
  int checks = 0, errors = 0, rises = 0, falls = 0, sckViol = 0, fallIdx = 0;

  always #5 clk = ~clk;

  sm_als_spi_master dut (
    .clk(clk), .rst_n(rst_n), .start(start & !sel), .busy(busy1), .valid(valid1),
    .value(value1), .frameErr(err1), .alsCS(cs1), .alsSCK(sck1), .alsSDO(sdo)
  );

  sm_als_spi_master #(.SCK_DIV(1), .CS_SETUP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(busy2), .valid(valid2),
    .value(value2), .frameErr(err2), .alsCS(cs2), .alsSCK(sck2), .alsSDO(sdo)
  );

  assign {busy, valid, err, cs, sck, value} = sel ? {busy2, valid2, err2, cs2, sck2, value2}
                                                  : {busy1, valid1, err1, cs1, sck1, value1};

  // ADC slave: CS falling rewinds the frame, each SCK fall presents the next bit MSB first.
  always @(negedge sck or negedge cs) begin
    if (sck === 1'b1) fallIdx = 0;
    else if (cs === 1'b0) begin
      sdo = (fallIdx < 16) ? frame[15 - fallIdx] : 1'b0;
      fallIdx++;
      falls++;
    end
  end

  always @(posedge sck) if (cs === 1'b0) rises++;
  always @(sck) if (cs === 1'b1 && rst_n === 1'b1) sckViol++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runFrame(input logic [15:0] f, input int lat, input int q, input string tag);
    int k = 0, vEdge = -1, vCount = 0, bFall = -1, csLow, r0, f0;
    logic [7:0] ev;
    logic ee;
    ev = 8'((f >> 5) & 16'h00FF);
    ee = (f & 16'hE01F) != 16'h0000;
    frame = f;
    r0 = rises;
    f0 = falls;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 1);
    chk({tag, "_cs_low"}, 32'(cs), 0);
    csLow = (cs === 1'b0) ? 1 : 0;
    while (bFall < 0 && k < 1000) begin
      @(negedge clk);
      k++;
      if (valid === 1'b1) begin
        vCount++;
        if (vEdge < 0) vEdge = k;
      end
      if (cs === 1'b0) csLow++;
      if (busy === 1'b0) bFall = k;
    end
    chk({tag, "_valid_edge"}, 32'(vEdge), 32'(lat));
    chk({tag, "_valid_count"}, 32'(vCount), 1);
    chk({tag, "_busy_fall"}, 32'(bFall), 32'(lat + q));
    chk({tag, "_value"}, 32'(value), 32'(ev));
    chk({tag, "_frame_err"}, 32'(err), 32'(ee));
    chk({tag, "_sck_rises"}, 32'(rises - r0), 16);
    chk({tag, "_sck_falls"}, 32'(falls - f0), 16);
    chk({tag, "_cs_low_cycles"}, 32'(csLow), 32'(lat));
  endtask

  initial begin
    int vq[$], cq[$], bq[$];
    int vc;
    logic pc, pb;
    logic [15:0] f;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sck", 32'(sck), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_frame_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    runFrame(16'b000_10100101_00000, 131, 8, "a5");

    frame = 16'b000_01011010_00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (valid === 1'b1) vc++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs), 1);
    chk("midrst_sck", 32'(sck), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_value", 32'(value), 0);
    repeat (3) begin
      @(negedge clk);
      if (valid === 1'b1) vc++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (valid === 1'b1) vc++;
    chk("midrst_no_valid", 32'(vc), 0);
    runFrame(16'b000_00111100_00000, 131, 8, "post_rst");

    runFrame(16'b111_00000000_00000, 131, 8, "pad_err");

    for (int i = 0; i < 6; i++) begin
      f = 16'($urandom);
      if (i % 2 == 0) f = f & 16'h1FE0;
      runFrame(f, 131, 8, "rnd");
    end

    frame = 16'b000_11000011_00000;
    pc = cs;
    pb = busy;
    start = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (valid === 1'b1) vq.push_back(k);
      if (pc === 1'b1 && cs === 1'b0) cq.push_back(k);
      if (pb === 1'b1 && busy === 1'b0) bq.push_back(k);
      pc = cs;
      pb = busy;
      if (k == 274) start = 1'b0;
      if (k > 274 && busy === 1'b0) break;
    end
    start = 1'b0;
    chk("hold_valid_count", 32'(vq.size()), 2);
    chk("hold_valid0", 32'(vq.size() > 0 ? vq[0] : -1), 131);
    chk("hold_valid1", 32'(vq.size() > 1 ? vq[1] : -1), 271);
    chk("hold_cs_falls", 32'(cq.size()), 2);
    chk("hold_busy_fall0", 32'(bq.size() > 0 ? bq[0] : -1), 139);
    chk("hold_cs_fall1", 32'(cq.size() > 1 ? cq[1] : -1), 140);
    chk("hold_value", 32'(value), 32'h000000C3);
    @(negedge clk);

    sel = 1'b1;
    @(negedge clk);
    runFrame(16'b000_11111111_00000, 34, 8, "div1");
    sel = 1'b0;

    chk("sck_toggle_cs_high", 32'(sckViol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
